// File: rtl/cal_pkg.sv
// Shared constants and types for the calendar counter stage.
package cal_pkg;

  typedef enum logic [1:0] {
    POS_DATE  = 2'd0,
    POS_MONTH = 2'd1,
    POS_YEAR  = 2'd2,
    POS_DOW   = 2'd3
  } pos_e;

  localparam logic       MODE_CLOCK = 1'b0;
  localparam logic       MODE_SETUP = 1'b1;

  localparam logic [3:0] MONTH_FEB = 4'd2;
  localparam logic [3:0] MONTH_DEC = 4'd12;
  localparam logic [6:0] YEAR_MAX  = 7'd99;
  localparam logic [2:0] DOW_MAX   = 3'd6;

endpackage

// File: rtl/cal_cnt_month_len.sv
// Days in a month for years 2000-2099; every fourth year (year[1:0]==0) is leap.
module month_len
  import cal_pkg::*;
(
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [4:0] days
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    days = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      MONTH_FEB:               days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
  end

endmodule

// File: rtl/cal_cnt.sv
// Calendar counter: date/month/year/day-of-week driven by a daily tick,
// with per-field increments in setup mode.
module cal_cnt
  import cal_pkg::*;
#(
  parameter logic [2:0] START_DOW = 3'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_day_tick,
  input  logic       i_mode,
  input  logic [1:0] i_position,
  input  logic       i_inc,
  output logic [4:0] o_date,
  output logic [3:0] o_month,
  output logic [6:0] o_year,
  output logic [2:0] o_dow,
  output logic       o_max_hit_year
);

  logic [4:0] date_q, date_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_q, year_d;
  logic [2:0] dow_q, dow_d;
  logic       hit_q, hit_d;

  logic [3:0] month_inc;
  logic [6:0] year_inc;
  logic [2:0] dow_inc;
  logic [3:0] clamp_month;
  logic [6:0] clamp_year;
  logic [4:0] cur_len;
  logic [4:0] clamp_len;
  pos_e       pos;

  assign pos       = pos_e'(i_position);
  assign month_inc = (month_q == MONTH_DEC) ? 4'd1 : month_q + 4'd1;
  assign year_inc  = (year_q == YEAR_MAX)   ? 7'd0 : year_q + 7'd1;
  assign dow_inc   = (dow_q == DOW_MAX)     ? 3'd0 : dow_q + 3'd1;

  // Month/year as they will be after a setup increment, so the date clamp
  // sees the new month length in the same cycle.
  assign clamp_month = (pos == POS_MONTH) ? month_inc : month_q;
  assign clamp_year  = (pos == POS_YEAR)  ? year_inc  : year_q;

  month_len u_cur_len (
    .month (month_q),
    .year  (year_q),
    .days  (cur_len)
  );

  month_len u_clamp_len (
    .month (clamp_month),
    .year  (clamp_year),
    .days  (clamp_len)
  );

  always_comb begin
    date_d  = date_q;
    month_d = month_q;
    year_d  = year_q;
    dow_d   = dow_q;
    hit_d   = 1'b0;

    if (i_mode == MODE_CLOCK) begin
      if (i_day_tick) begin
        dow_d = dow_inc;
        if (date_q < cur_len) begin
          date_d = date_q + 5'd1;
        end else begin
          date_d = 5'd1;
          if (month_q < MONTH_DEC) begin
            month_d = month_q + 4'd1;
          end else begin
            month_d = 4'd1;
            year_d  = year_inc;
            hit_d   = (year_q == YEAR_MAX);
          end
        end
      end
    end else if (i_inc) begin
      case (pos)
        POS_DATE:  date_d = (date_q >= cur_len) ? 5'd1 : date_q + 5'd1;
        POS_MONTH: begin
          month_d = clamp_month;
          date_d  = (date_q > clamp_len) ? clamp_len : date_q;
        end
        POS_YEAR: begin
          year_d = clamp_year;
          date_d = (date_q > clamp_len) ? clamp_len : date_q;
        end
        POS_DOW:   dow_d = dow_inc;
        default:   dow_d = dow_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      date_q  <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 7'd0;
      dow_q   <= START_DOW;
      hit_q   <= 1'b0;
    end else begin
      date_q  <= date_d;
      month_q <= month_d;
      year_q  <= year_d;
      dow_q   <= dow_d;
      hit_q   <= hit_d;
    end
  end

  assign o_date         = date_q;
  assign o_month        = month_q;
  assign o_year         = year_q;
  assign o_dow          = dow_q;
  assign o_max_hit_year = hit_q;

endmodule

// File: tb/tb_cal_cnt.sv
// Self-checking bench for cal_cnt: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a field-level calendar model.
module tb_cal_cnt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_day_tick = 1'b0;
  logic       i_mode = 1'b0;
  logic [1:0] i_position = 2'd0;
  logic       i_inc = 1'b0;
  logic [4:0] o_date;
  logic [3:0] o_month;
  logic [6:0] o_year;
  logic [2:0] o_dow;
  logic       o_max_hit_year;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  cal_cnt #(.START_DOW(3'd6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_day_tick     (i_day_tick),
    .i_mode         (i_mode),
    .i_position     (i_position),
    .i_inc          (i_inc),
    .o_date         (o_date),
    .o_month        (o_month),
    .o_year         (o_year),
    .o_dow          (o_dow),
    .o_max_hit_year (o_max_hit_year)
  );

  typedef struct {
    string name;
    int    sy, sm, sd, sdow;
    bit    mode;
    int    pos;
    bit    tick, inc;
    int    ey, em, ed, edow;
    bit    hit;
  } vec_t;

  vec_t vecs[$];

  // Reference calendar state.
  int m_y, m_m, m_d, m_dow;
  bit m_hit;

  function automatic int mlen(int m, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4) == 0) return 29;
    return t[m-1];
  endfunction

  function automatic logic [19:0] pack(int y, int m, int d, int dow, bit h);
    return {7'(y), 4'(m), 5'(d), 3'(dow), h};
  endfunction

  function automatic logic [19:0] dut_state();
    return {o_year, o_month, o_date, o_dow, o_max_hit_year};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (y,m,d,dow,hit packed)", name, got, exp);
    end
  endtask

  task automatic model_step(input bit mode, input int pos, input bit tick, input bit inc);
    m_hit = 1'b0;
    if (!mode) begin
      if (tick) begin
        m_dow = (m_dow + 1) % 7;
        if (m_d < mlen(m_m, m_y)) m_d++;
        else begin
          m_d = 1;
          if (m_m < 12) m_m++;
          else begin
            m_m = 1;
            if (m_y == 99) begin m_y = 0; m_hit = 1'b1; end
            else m_y++;
          end
        end
      end
    end else if (inc) begin
      case (pos)
        0: m_d = (m_d >= mlen(m_m, m_y)) ? 1 : m_d + 1;
        1: begin
          m_m = (m_m % 12) + 1;
          if (m_d > mlen(m_m, m_y)) m_d = mlen(m_m, m_y);
        end
        2: begin
          m_y = (m_y + 1) % 100;
          if (m_d > mlen(m_m, m_y)) m_d = mlen(m_m, m_y);
        end
        default: m_dow = (m_dow + 1) % 7;
      endcase
    end
  endtask

  // Called at posedge+1; inputs are captured on the next posedge and
  // outputs are sampled 1 time unit after it.
  task automatic apply(input bit mode, input int pos, input bit tick, input bit inc);
    i_mode     = mode;
    i_position = 2'(pos);
    i_day_tick = tick;
    i_inc      = inc;
    @(posedge clk);
    #1;
    i_day_tick = 1'b0;
    i_inc      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_y = 0; m_m = 1; m_d = 1; m_dow = 6; m_hit = 1'b0;
  endtask

  task automatic set_date(input int y, input int m, input int d, input int dow);
    do_reset();
    for (int i = 0; i < y; i++)         apply(1'b1, 2, 1'b0, 1'b1);
    for (int i = 0; i < m - 1; i++)     apply(1'b1, 1, 1'b0, 1'b1);
    for (int i = 0; i < d - 1; i++)     apply(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < (dow + 1) % 7; i++) apply(1'b1, 3, 1'b0, 1'b1);
    i_mode = 1'b0;
    m_y = y; m_m = m; m_d = d; m_dow = dow; m_hit = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"jan31_rollover", 23, 1, 31, 2, 1'b0, 0, 1'b1, 1'b0, 23, 2, 1, 3, 1'b0});
    vecs.push_back('{"leap24_feb28",   24, 2, 28, 4, 1'b0, 0, 1'b1, 1'b0, 24, 2, 29, 5, 1'b0});
    vecs.push_back('{"y23_feb28",      23, 2, 28, 1, 1'b0, 0, 1'b1, 1'b0, 23, 3, 1, 2, 1'b0});
    vecs.push_back('{"y00_feb28",       0, 2, 28, 1, 1'b0, 0, 1'b1, 1'b0,  0, 2, 29, 2, 1'b0});
    vecs.push_back('{"century_wrap",   99, 12, 31, 0, 1'b0, 0, 1'b1, 1'b0, 0, 1, 1, 1, 1'b1});
    vecs.push_back('{"y98_dec31",      98, 12, 31, 6, 1'b0, 0, 1'b1, 1'b0, 99, 1, 1, 0, 1'b0});
    vecs.push_back('{"clamp_mar31",    24, 3, 31, 3, 1'b1, 1, 1'b0, 1'b1, 24, 4, 30, 3, 1'b0});
    vecs.push_back('{"clamp_feb29",    24, 2, 29, 3, 1'b1, 2, 1'b0, 1'b1, 25, 2, 28, 3, 1'b0});
    vecs.push_back('{"date_wrap_apr",  24, 4, 30, 5, 1'b1, 0, 1'b0, 1'b1, 24, 4, 1, 5, 1'b0});
    vecs.push_back('{"tick_in_setup",  24, 5, 10, 2, 1'b1, 0, 1'b1, 1'b0, 24, 5, 10, 2, 1'b0});
    vecs.push_back('{"inc_in_clock",   24, 5, 10, 2, 1'b0, 0, 1'b0, 1'b1, 24, 5, 10, 2, 1'b0});
    vecs.push_back('{"dow_wrap",       10, 7, 4, 6, 1'b1, 3, 1'b0, 1'b1, 10, 7, 4, 0, 1'b0});
    vecs.push_back('{"month_dec_wrap", 24, 12, 31, 1, 1'b1, 1, 1'b0, 1'b1, 24, 1, 31, 1, 1'b0});
    vecs.push_back('{"date_feb29_wrap",24, 2, 29, 1, 1'b1, 0, 1'b0, 1'b1, 24, 2, 1, 1, 1'b0});
    vecs.push_back('{"year99_setup",   99, 6, 15, 3, 1'b1, 2, 1'b0, 1'b1,  0, 6, 15, 3, 1'b0});

    // Reset values.
    do_reset();
    check("reset_state", 32'(dut_state()), 32'(pack(0, 1, 1, 6, 1'b0)));

    // Table-driven single-step vectors.
    foreach (vecs[i]) begin
      set_date(vecs[i].sy, vecs[i].sm, vecs[i].sd, vecs[i].sdow);
      check({vecs[i].name, "_pre"}, 32'(dut_state()),
            32'(pack(vecs[i].sy, vecs[i].sm, vecs[i].sd, vecs[i].sdow, 1'b0)));
      apply(vecs[i].mode, vecs[i].pos, vecs[i].tick, vecs[i].inc);
      check(vecs[i].name, 32'(dut_state()),
            32'(pack(vecs[i].ey, vecs[i].em, vecs[i].ed, vecs[i].edow, vecs[i].hit)));
    end

    // Leap year: two consecutive ticks Feb 28 -> Feb 29 -> Mar 1.
    set_date(24, 2, 28, 3);
    apply(1'b0, 0, 1'b1, 1'b0);
    apply(1'b0, 0, 1'b1, 1'b0);
    check("leap_back_to_back", 32'(dut_state()), 32'(pack(24, 3, 1, 5, 1'b0)));

    // Century pulse is exactly one cycle wide.
    set_date(99, 12, 31, 2);
    apply(1'b0, 0, 1'b1, 1'b0);
    check("century_pulse_hi", 32'(dut_state()), 32'(pack(0, 1, 1, 3, 1'b1)));
    apply(1'b0, 0, 1'b0, 1'b0);
    check("century_pulse_lo", 32'(dut_state()), 32'(pack(0, 1, 1, 3, 1'b0)));

    // 40 ticks from reset, then asynchronous reset mid-cycle.
    do_reset();
    for (int i = 0; i < 40; i++) apply(1'b0, 0, 1'b1, 1'b0);
    check("forty_ticks", 32'(dut_state()), 32'(pack(0, 2, 10, 4, 1'b0)));
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_state()), 32'(pack(0, 1, 1, 6, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized mix against the calendar model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit mode, tick, inc;
      int pos;
      mode = ($urandom_range(0, 3) == 0);
      pos  = int'($urandom_range(0, 3));
      tick = $urandom_range(0, 1) == 1;
      inc  = $urandom_range(0, 1) == 1;
      apply(mode, pos, tick, inc);
      model_step(mode, pos, tick, inc);
      check($sformatf("random_%0d", n), 32'(dut_state()),
            32'(pack(m_y, m_m, m_d, m_dow, m_hit)));
      if (m_d > mlen(m_m, m_y)) begin
        errors++;
        $display("FAIL model_range_%0d: date %0d exceeds %0d", n, m_d, mlen(m_m, m_y));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
